// File: rtl/color_pkg.sv
// Shared widths, gain constants, pixel/gain typedefs and the fade FSM state encoding
// for the runtime-gain pixel scaler.
package color_pkg;
  localparam int CH_W     = 8;
  localparam int NUM_CH   = 3;
  localparam int GAIN_W   = 8;
  localparam int GAIN_ONE = 1 << GAIN_W;

  typedef logic [NUM_CH*CH_W-1:0] pixel_t;
  typedef logic [GAIN_W:0]        gain_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } fade_state_t;
endpackage

// File: rtl/scale_fade_ch.sv
// One colour channel: (ch * gain) >> GAIN_W, saturated to the channel range.
// Build option SCALE_FADE_ROUND_EN: round-half-up before the shift instead of truncating.
module scale_fade_ch
  import color_pkg::*;
#(
  parameter int CH_W   = color_pkg::CH_W,
  parameter int GAIN_W = color_pkg::GAIN_W
) (
  input  logic [CH_W-1:0] ch,
  input  logic [GAIN_W:0] gain,
  output logic [CH_W-1:0] res
);
  // One spare bit above the raw product keeps the rounding carry.
  localparam int PW = CH_W + GAIN_W + 2;

  logic [PW-1:0]        prod;
  logic [PW-1:0]        sum;
  logic [PW-GAIN_W-1:0] shifted;

  assign prod = PW'(ch) * PW'(gain);
`ifdef SCALE_FADE_ROUND_EN
  assign sum  = prod + PW'(1 << (GAIN_W - 1));
`else
  assign sum  = prod;
`endif
  assign shifted = sum[PW-1:GAIN_W];
  assign res     = (shifted[PW-GAIN_W-1:CH_W] != '0) ? '1 : shifted[CH_W-1:0];
endmodule

// File: rtl/scale_fade_pipe.sv
// Two-stage valid/ready pixel scaler with a runtime gain that ramps toward a target per fade_tick.
// Build option SCALE_FADE_ROUND_EN selects round-half-up in the channel arithmetic.
module scale_fade_pipe
  import color_pkg::*;
#(
  parameter int CH_W       = color_pkg::CH_W,
  parameter int NUM_CH     = color_pkg::NUM_CH,
  parameter int GAIN_W     = color_pkg::GAIN_W,
  parameter int RESET_GAIN = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CH*CH_W-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH*CH_W-1:0] out_pixel,
  input  logic                   fade_start,
  input  logic [GAIN_W:0]        fade_target,
  input  logic [GAIN_W:0]        fade_step,
  input  logic                   fade_tick,
  output logic                   fade_busy,
  output logic [GAIN_W:0]        cur_gain
);
  localparam int STAGES = 2;
  localparam logic [GAIN_W:0] G_ONE = (GAIN_W+1)'(1 << GAIN_W);
  localparam logic [GAIN_W:0] G_RST = (GAIN_W+1)'(RESET_GAIN);

  // ---------------- pipeline ----------------
  logic                               en;
  logic [STAGES:1]                    vld_pipe;
  logic [NUM_CH-1:0][CH_W-1:0]        s1_pix;
  logic [GAIN_W:0]                    s1_gain;
  logic [NUM_CH-1:0][CH_W-1:0]        scaled;
  logic [NUM_CH-1:0][CH_W-1:0]        out_pix;

  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign out_pixel = out_pix;

  // Whole pipe advances together; a bubble in S1 still waits behind a stalled output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_pix   <= '0;
      s1_gain  <= '0;
      out_pix  <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) begin
        s1_pix  <= in_pixel;
        s1_gain <= cur_gain;
      end
      if (vld_pipe[1]) out_pix <= scaled;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    scale_fade_ch #(.CH_W(CH_W), .GAIN_W(GAIN_W)) u_ch (
      .ch   (s1_pix[g]),
      .gain (s1_gain),
      .res  (scaled[g])
    );
  end

  // ---------------- fade FSM ----------------
  fade_state_t     state, state_nxt;
  logic [GAIN_W:0] gain_nxt, tgt, tgt_nxt, step, step_nxt, tgt_clamp;

  assign tgt_clamp = (fade_target > G_ONE) ? G_ONE : fade_target;
  assign fade_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_gain <= G_RST;
      tgt      <= G_RST;
      step     <= '0;
    end else begin
      state    <= state_nxt;
      cur_gain <= gain_nxt;
      tgt      <= tgt_nxt;
      step     <= step_nxt;
    end
  end

  // A start always wins over a same-cycle tick and retargets from the present gain.
  always_comb begin
    state_nxt = state;
    gain_nxt  = cur_gain;
    tgt_nxt   = tgt;
    step_nxt  = step;
    if (fade_start) begin
      tgt_nxt  = tgt_clamp;
      step_nxt = fade_step;
      if (fade_step == '0 || tgt_clamp == cur_gain) begin
        gain_nxt  = tgt_clamp;
        state_nxt = IDLE;
      end else if (tgt_clamp > cur_gain) begin
        state_nxt = RAMP_UP;
      end else begin
        state_nxt = RAMP_DOWN;
      end
    end else if (fade_tick) begin
      case (state)
        RAMP_UP: begin
          if (tgt - cur_gain <= step) begin
            gain_nxt  = tgt;
            state_nxt = IDLE;
          end else begin
            gain_nxt = cur_gain + step;
          end
        end
        RAMP_DOWN: begin
          if (cur_gain - tgt <= step) begin
            gain_nxt  = tgt;
            state_nxt = IDLE;
          end else begin
            gain_nxt = cur_gain - step;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_scale_fade_pipe.sv
// Directed bench for scale_fade_pipe: gain application, fade ramps, backpressure, async reset.
module tb_scale_fade_pipe;
  import color_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   in_valid, in_ready, out_valid, out_ready;
  pixel_t in_pixel, out_pixel;
  logic   fade_start, fade_tick, fade_busy;
  gain_t  fade_target, fade_step, cur_gain;

  always #5 clk = ~clk;

  scale_fade_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .fade_start  (fade_start),
    .fade_target (fade_target),
    .fade_step   (fade_step),
    .fade_tick   (fade_tick),
    .fade_busy   (fade_busy),
    .cur_gain    (cur_gain)
  );

`ifdef SCALE_FADE_ROUND_EN
  localparam pixel_t EXP_HALF = 24'h808080;
  localparam pixel_t EXP_QTR  = 24'h404040;
`else
  localparam pixel_t EXP_HALF = 24'h7F7F7F;
  localparam pixel_t EXP_QTR  = 24'h3F3F3F;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input pixel_t pix, input pixel_t exp);
    in_valid = 1'b1;
    in_pixel = pix;
    step_clk();
    in_valid = 1'b0;
    step_clk();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_pix"}, 32'(out_pixel), 32'(exp));
  endtask

  task automatic start(input int tgt, input int stp);
    fade_start  = 1'b1;
    fade_target = gain_t'(tgt);
    fade_step   = gain_t'(stp);
    step_clk();
    fade_start  = 1'b0;
  endtask

  task automatic tick();
    fade_tick = 1'b1;
    step_clk();
    fade_tick = 1'b0;
  endtask

  // Output monitor for the burst test: a transfer happens on the next rising edge.
  logic   mon_en = 1'b0;
  pixel_t got[$];
  always @(negedge clk)
    if (mon_en && out_valid && out_ready) got.push_back(out_pixel);

  pixel_t burst[10];
  pixel_t held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    fade_start = 1'b0; fade_tick = 1'b0; fade_target = '0; fade_step = '0;
    #1;
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_opix", 32'(out_pixel), 32'd0);
    chk("rst_busy", 32'(fade_busy), 32'd0);
    chk("rst_gain", 32'(cur_gain), 32'd256);
    chk("rst_irdy", 32'(in_ready), 32'd1);
    step_clk(); step_clk();
    rst = 1'b0;
    step_clk();

    // 1: unity gain passes pixels through
    send_one("unity_red", 24'hFF0000, 24'hFF0000);
    send_one("unity_7f",  24'h7F7F7F, 24'h7F7F7F);

    // 2: immediate jumps
    start(128, 0);
    chk("jump128_gain", 32'(cur_gain), 32'd128);
    chk("jump128_busy", 32'(fade_busy), 32'd0);
    send_one("half", 24'hFFFFFF, EXP_HALF);
    start(64, 0);
    chk("jump64_gain", 32'(cur_gain), 32'd64);
    send_one("qtr", 24'hFFFFFF, EXP_QTR);
    start(300, 0);
    chk("clamp_gain", 32'(cur_gain), 32'd256);

    // 3: ramp down 256 -> 0 in steps of 100
    start(0, 100);
    chk("rd_start_gain", 32'(cur_gain), 32'd256);
    chk("rd_start_busy", 32'(fade_busy), 32'd1);
    tick(); chk("rd_t1", 32'(cur_gain), 32'd156);
    tick(); chk("rd_t2", 32'(cur_gain), 32'd56);
    chk("rd_t2_busy", 32'(fade_busy), 32'd1);
    tick(); chk("rd_t3", 32'(cur_gain), 32'd0);
    chk("rd_t3_busy", 32'(fade_busy), 32'd0);
    tick(); chk("rd_extra", 32'(cur_gain), 32'd0);
    start(128, 0);
    tick(); chk("idle_tick", 32'(cur_gain), 32'd128);

    // 4: start+tick same cycle, then mid-ramp retarget
    fade_tick = 1'b1;
    start(200, 10);
    fade_tick = 1'b0;
    chk("st_tick_gain", 32'(cur_gain), 32'd128);
    chk("st_tick_busy", 32'(fade_busy), 32'd1);
    start(256, 0);
    start(0, 100);
    tick(); chk("rt_t1", 32'(cur_gain), 32'd156);
    start(200, 30);
    chk("rt_start", 32'(cur_gain), 32'd156);
    tick(); chk("rt_t2", 32'(cur_gain), 32'd186);
    tick(); chk("rt_t3", 32'(cur_gain), 32'd200);
    chk("rt_busy", 32'(fade_busy), 32'd0);

    // 5: 10-pixel burst with a 3-cycle output stall
    start(256, 0);
    for (int i = 0; i < 10; i++) burst[i] = pixel_t'(24'h102030 + i * 24'h010203);
    got.delete();
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int w;
          in_valid = 1'b1;
          in_pixel = burst[i];
          w = 0;
          @(negedge clk);
          while (!in_ready && w < 20) begin
            w++;
            @(negedge clk);
          end
          if (w >= 20) chk("drv_timeout", 32'(w), 32'd0);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_irdy", 32'(in_ready), 32'd0);
        chk("stall_ovld", 32'(out_valid), 32'd1);
        held = out_pixel;
        repeat (2) begin
          @(negedge clk);
          chk("stall_hold", 32'(out_pixel), 32'(held));
          chk("stall_vld",  32'(out_valid), 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && got.size() < 10; k++) step_clk();
    mon_en = 1'b0;
    chk("burst_cnt", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("burst_pix", 32'(got[i]), 32'(burst[i]));

    // 6: async reset with a ramp running and two pixels in flight
    start(0, 100);
    tick();
    in_valid = 1'b1; in_pixel = 24'hAABBCC;
    step_clk();
    in_pixel = 24'h112233;
    step_clk();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ovld", 32'(out_valid), 32'd0);
    chk("arst_gain", 32'(cur_gain), 32'd256);
    chk("arst_busy", 32'(fade_busy), 32'd0);
    #1 rst = 1'b0;
    step_clk();
    chk("post_rst_ovld", 32'(out_valid), 32'd0);
    chk("post_rst_irdy", 32'(in_ready), 32'd1);
    send_one("resume", 24'h123456, 24'h123456);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
